// File: rtl/music_box_pkg.sv
// Shared constants and state encoding for the music box audio path.
package music_box_pkg;

    // System clock frequency; tone counts are expressed in these cycles.
    localparam int CLK_FREQ_HZ = 100_000_000;

    // Width of the half-period count coming from the scale lookup stage.
    localparam int CNT_W = 20;

    // Smallest half-period count that is treated as a tone; anything lower is silence.
    localparam int MIN_COUNT = 2;

    // Tone generator control states.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        STOP_PEND = 2'd2
    } tone_state_t;

endpackage : music_box_pkg

// File: rtl/pwm_volume.sv
// Free-running 4-bit PWM volume gate applied to the raw square wave.
module pwm_volume #(
    parameter int PWM_DIV = 4
) (
    input  logic       clk,
    input  logic       reset_,
    input  logic       tone_phase,
    input  logic [3:0] volume,
    output logic       audio_out
);

    localparam int PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PWM_DIV - 1);

    logic [PRE_W-1:0] pre;
    logic [3:0]       pwm_cnt;
    logic             gate_on;

    // Full volume bypasses the PWM so the output is solid while the tone is high.
    assign gate_on = (volume == 4'hF) || (pwm_cnt < volume);

    // Pre-divider and PWM step counter, free-running regardless of tone state.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            pre     <= '0;
            pwm_cnt <= '0;
        end else if (pre == PRE_MAX) begin
            pre     <= '0;
            pwm_cnt <= pwm_cnt + 4'd1;
        end else begin
            pre     <= pre + PRE_W'(1);
        end
    end

    // Registered volume gate; audio_out trails tone_phase by one cycle.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            audio_out <= 1'b0;
        end else begin
            audio_out <= tone_phase & gate_on;
        end
    end

endmodule : pwm_volume

// File: rtl/tone_gen.sv
// Square-wave tone generator: half-period counter with boundary-aligned
// frequency changes and stop requests, followed by a PWM volume gate.
module tone_gen #(
    parameter int CNT_W     = music_box_pkg::CNT_W,
    parameter int MIN_COUNT = music_box_pkg::MIN_COUNT,
    parameter int PWM_DIV   = 4
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic             enable,
    input  logic [CNT_W-1:0] count,
    input  logic [3:0]       volume,
    output logic             tone_phase,
    output logic             audio_out,
    output logic             half_tick,
    output logic             busy
);

    import music_box_pkg::*;

    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_COUNT);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    tone_state_t      state;
    logic [CNT_W-1:0] hp_cnt;
    logic [CNT_W-1:0] act_cnt;
    logic             boundary;
    logic             count_ok;

    // act_cnt >= MIN_COUNT whenever this is evaluated (RUN/STOP_PEND), so no wrap.
    assign boundary = (hp_cnt == (act_cnt - ONE));
    assign count_ok = (count >= MIN_C);
    assign busy     = (state != IDLE);

    // Tone control FSM: counts half-periods, resamples count and honours
    // stop requests only on half-period boundaries.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state      <= IDLE;
            hp_cnt     <= '0;
            act_cnt    <= '0;
            tone_phase <= 1'b0;
            half_tick  <= 1'b0;
        end else begin
            half_tick <= 1'b0;
            case (state)
                IDLE: begin
                    hp_cnt     <= '0;
                    tone_phase <= 1'b0;
                    if (enable && count_ok) begin
                        state      <= RUN;
                        act_cnt    <= count;
                        tone_phase <= 1'b1;
                    end
                end
                RUN, STOP_PEND: begin
                    if (boundary && ((state == RUN) || enable)) begin
                        // Normal boundary: resample count, toggle or fall silent.
                        hp_cnt    <= '0;
                        half_tick <= 1'b1;
                        act_cnt   <= count;
                        if (!count_ok) begin
                            state      <= IDLE;
                            tone_phase <= 1'b0;
                        end else begin
                            tone_phase <= ~tone_phase;
                            state      <= enable ? RUN : STOP_PEND;
                        end
                    end else if (boundary) begin
                        // Pending stop completes on this boundary.
                        hp_cnt     <= '0;
                        half_tick  <= 1'b1;
                        tone_phase <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        hp_cnt <= hp_cnt + ONE;
                        state  <= enable ? RUN : STOP_PEND;
                    end
                end
                default: begin
                    state      <= IDLE;
                    hp_cnt     <= '0;
                    tone_phase <= 1'b0;
                end
            endcase
        end
    end

    pwm_volume #(
        .PWM_DIV (PWM_DIV)
    ) u_pwm_volume (
        .clk        (clk),
        .reset_     (reset_),
        .tone_phase (tone_phase),
        .volume     (volume),
        .audio_out  (audio_out)
    );

endmodule : tone_gen

// File: tb/tb_tone_gen.sv
// Directed and randomized bench for tone_gen with a cycle-level reference model.
module tb_tone_gen;

    localparam int CNT_W     = 20;
    localparam int MIN_COUNT = 2;
    localparam int PWM_DIV   = 4;

    logic             clk    = 1'b0;
    logic             reset_ = 1'b0;
    logic             enable = 1'b0;
    logic [CNT_W-1:0] count  = '0;
    logic [3:0]       volume = 4'd0;
    logic             tone_phase;
    logic             audio_out;
    logic             half_tick;
    logic             busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    tone_gen #(
        .CNT_W     (CNT_W),
        .MIN_COUNT (MIN_COUNT),
        .PWM_DIV   (PWM_DIV)
    ) dut (
        .clk        (clk),
        .reset_     (reset_),
        .enable     (enable),
        .count      (count),
        .volume     (volume),
        .tone_phase (tone_phase),
        .audio_out  (audio_out),
        .half_tick  (half_tick),
        .busy       (busy)
    );

    // Reference model: a tone is either playing or not; a playing half lasts
    // m_left more edges; a stop request is remembered if enable was low last edge.
    bit    m_run   = 1'b0;
    bit    m_phase = 1'b0;
    bit    m_tick  = 1'b0;
    bit    m_audio = 1'b0;
    bit    m_pend  = 1'b0;
    int    m_left  = 0;
    longint m_cyc  = 0;

    always @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            m_run = 0; m_phase = 0; m_tick = 0; m_audio = 0; m_pend = 0;
            m_left = 0; m_cyc = 0;
        end else begin
            m_audio = m_phase && ((volume == 4'd15) || (((m_cyc / PWM_DIV) % 16) < longint'(volume)));
            m_cyc++;
            m_tick = 0;
            if (!m_run) begin
                if (enable && (int'(count) >= MIN_COUNT)) begin
                    m_run   = 1;
                    m_phase = 1;
                    m_left  = int'(count);
                    m_pend  = 0;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_tick = 1;
                    if ((m_pend && !enable) || (int'(count) < MIN_COUNT)) begin
                        m_run   = 0;
                        m_phase = 0;
                    end else begin
                        m_phase = !m_phase;
                        m_left  = int'(count);
                    end
                end
                m_pend = m_run && !enable;
            end
        end
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0b expected %0b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock and compare every output against the model mid-cycle.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        chk("tone_phase", tone_phase, m_phase);
        chk("half_tick",  half_tick,  m_tick);
        chk("busy",       busy,       m_run);
        chk("audio_out",  audio_out,  m_audio);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_idle(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (!busy) break;
            tick();
        end
        chk("wait_idle_busy", busy, 1'b0);
    endtask

    initial begin
        int highs;

        // Reset state.
        ticks(3);
        chk("reset_busy", busy, 1'b0);
        chk("reset_phase", tone_phase, 1'b0);
        reset_ = 1'b1;

        // count=0 with enable held: stays silent.
        enable = 1'b1;
        count  = '0;
        ticks(100);
        chk("cnt0_busy", busy, 1'b0);
        chk("cnt0_audio", audio_out, 1'b0);

        // count=5 at full volume.
        count  = 20'd5;
        volume = 4'd15;
        tick();
        chk("cnt5_rise", tone_phase, 1'b1);
        ticks(4);
        chk("cnt5_still_high", tone_phase, 1'b1);
        tick();
        chk("cnt5_toggle", tone_phase, 1'b0);
        chk("cnt5_tick", half_tick, 1'b1);
        ticks(22);

        // Change to 8 mid-half: current half finishes at 5.
        ticks(2);
        count = 20'd8;
        ticks(40);

        // Stop request at hp_cnt=2 with count=6.
        enable = 1'b0;
        count  = 20'd6;
        wait_idle(40);
        enable = 1'b1;
        tick();
        chk("stop_rise", tone_phase, 1'b1);
        ticks(2);
        enable = 1'b0;
        ticks(3);
        chk("stop_pending_busy", busy, 1'b1);
        tick();
        chk("stop_done_busy", busy, 1'b0);
        chk("stop_done_phase", tone_phase, 1'b0);

        // Stop request withdrawn one cycle before the boundary.
        enable = 1'b1;
        tick();
        ticks(2);
        enable = 1'b0;
        ticks(2);
        enable = 1'b1;
        ticks(2);
        chk("resume_phase", tone_phase, 1'b0);
        chk("resume_busy", busy, 1'b1);
        ticks(6);
        chk("resume_next_half", tone_phase, 1'b1);

        // count drops below MIN_COUNT: silence at next boundary.
        count = 20'd1;
        wait_idle(20);
        chk("cnt1_phase", tone_phase, 1'b0);

        // Long tone with PWM volume 4: 16 of every 64 cycles high.
        count  = 20'd200;
        volume = 4'd4;
        ticks(11);
        highs = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (audio_out) highs++;
        end
        chk_int("pwm_vol4_highs", highs, 16);
        volume = 4'd0;
        tick();
        highs = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (audio_out) highs++;
        end
        chk_int("pwm_vol0_highs", highs, 0);

        // Asynchronous reset mid-tone.
        volume = 4'd15;
        ticks(3);
        chk("pre_reset_audio", audio_out, 1'b1);
        reset_ = 1'b0;
        #1;
        chk("areset_phase", tone_phase, 1'b0);
        chk("areset_audio", audio_out, 1'b0);
        chk("areset_tick", half_tick, 1'b0);
        chk("areset_busy", busy, 1'b0);
        tick();
        reset_ = 1'b1;
        ticks(3);

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            enable = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 5) == 0) count = CNT_W'($urandom_range(0, 9));
            volume = 4'($urandom_range(0, 15));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_tone_gen
